// File: rtl/bias_add_relu_stage_pkg.sv
// Shared widths and requantisation helpers for the bias/ReLU output stage.
// Helpers operate on a fixed 64-bit signed carrier so they work for any lane width.
package bias_add_relu_stage_pkg;

  localparam int unsigned LANES_DEF  = 16;
  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned BIAS_W_DEF = 18;
  localparam int unsigned OUT_W_DEF  = 16;
  localparam int unsigned SHIFT_DEF  = 8;
  localparam int unsigned GROUPS_DEF = 4;

  // Carrier width; every lane sum (ACC_W+1 bits) is sign-extended into this.
  localparam int unsigned SUM_MAX = 64;

  function automatic logic signed [SUM_MAX-1:0] sat_shift(
    input logic signed [SUM_MAX-1:0] sum,
    input int unsigned               shift,
    input int unsigned               out_w
  );
    logic signed [SUM_MAX-1:0] r;
    logic signed [SUM_MAX-1:0] one;
    logic signed [SUM_MAX-1:0] hi;
    logic signed [SUM_MAX-1:0] lo;
    one = SUM_MAX'(1);
    r   = sum >>> shift;
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -hi - one;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

  function automatic logic signed [SUM_MAX-1:0] relu_clamp(
    input logic signed [SUM_MAX-1:0] x
  );
    return x[SUM_MAX-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/bias_add_relu_stage_requant.sv
// Single-lane combinational requantiser: floor shift, saturate, optional ReLU.
module bias_lane_requant
  import bias_add_relu_stage_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned SHIFT   = SHIFT_DEF,
  parameter int unsigned RELU_EN = 1
)(
  input  logic [ACC_W:0]   sum,
  output logic [OUT_W-1:0] result
);

  logic signed [SUM_MAX-1:0] wide;
  logic signed [SUM_MAX-1:0] shaped;

  always_comb begin
    wide   = SUM_MAX'($signed(sum));
    shaped = sat_shift(wide, SHIFT, OUT_W);
    if (RELU_EN != 0) begin
      shaped = relu_clamp(shaped);
    end
    result = OUT_W'(shaped);
  end

endmodule

// File: rtl/bias_add_relu_stage.sv
// Bias add + requantise + ReLU output stage: 2-deep valid/ready pipeline and
// a channel-group counter that steers the upstream bias-bank mux via bias_sel.
module bias_add_relu_stage
  import bias_add_relu_stage_pkg::*;
#(
  parameter int unsigned N_adder_tree = LANES_DEF,
  parameter int unsigned ACC_W        = ACC_W_DEF,
  parameter int unsigned BIAS_W       = BIAS_W_DEF,
  parameter int unsigned OUT_W        = OUT_W_DEF,
  parameter int unsigned SHIFT        = SHIFT_DEF,
  parameter int unsigned NUM_GROUPS   = GROUPS_DEF,
  parameter int unsigned RELU_EN      = 1,
  localparam int unsigned SEL_W       = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_adder_tree*ACC_W-1:0]  in_acc,
  input  logic [N_adder_tree*BIAS_W-1:0] bias,
  output logic [SEL_W-1:0]               bias_sel,
  input  logic                           grp_clr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_adder_tree*OUT_W-1:0]  out_data
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic                            s1_valid;
  logic                            s2_valid;
  logic                            s2_adv;
  logic                            accept;
  logic [N_adder_tree*SUM_W-1:0]   sum_next;
  logic [N_adder_tree*SUM_W-1:0]   s1_sum;
  logic [N_adder_tree*OUT_W-1:0]   lane_out;

  // in_ready depends on out_ready and registered state only, never on in_valid.
  assign s2_adv    = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    logic [ACC_W-1:0]  acc;
    logic [BIAS_W-1:0] b;
    assign acc = in_acc[ACC_W*i +: ACC_W];
    assign b   = bias[BIAS_W*i +: BIAS_W];
    assign sum_next[SUM_W*i +: SUM_W] =
      {acc[ACC_W-1], acc} + {{(SUM_W-BIAS_W){b[BIAS_W-1]}}, b};

    bias_lane_requant #(
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT),
      .RELU_EN(RELU_EN)
    ) u_requant (
      .sum   (s1_sum[SUM_W*i +: SUM_W]),
      .result(lane_out[OUT_W*i +: OUT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= accept | (s1_valid & ~s2_adv);
      if (accept) begin
        s1_sum <= sum_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= lane_out;
      end
    end
  end

  // Clear has priority; a beat accepted alongside clear already used the old index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_sel <= '0;
    end else if (grp_clr) begin
      bias_sel <= '0;
    end else if (accept) begin
      bias_sel <= (bias_sel == SEL_W'(NUM_GROUPS - 1)) ? '0 : bias_sel + 1'b1;
    end
  end

endmodule

// File: tb/tb_bias_add_relu_stage.sv
// Scoreboard bench: two instances (ReLU on/off) share stimulus; a monitor
// pops hand-computed expectations whenever a result beat is handed off.
module tb_bias_add_relu_stage;

  localparam int N  = 16;
  localparam int AW = 32;
  localparam int BW = 18;
  localparam int OW = 16;

  typedef struct packed {
    logic [N*OW-1:0] er;
    logic [N*OW-1:0] en;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid;
  logic [N*AW-1:0]   in_acc;
  logic [N*BW-1:0]   bias_drv;
  logic [N*BW-1:0]   bias_a;
  logic [N*BW-1:0]   bias_b;
  logic              use_bank;
  logic              grp_clr;
  logic              out_ready;
  logic              in_ready_a, in_ready_b;
  logic [1:0]        sel_a, sel_b;
  logic              out_valid_a, out_valid_b;
  logic [N*OW-1:0]   out_data_a, out_data_b;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [31:0] v_acc [16];
  int          v_bias[16];
  int          v_er  [16];
  int          v_en  [16];

  always #5 clk = ~clk;

  bias_add_relu_stage #(
    .N_adder_tree(N), .ACC_W(AW), .BIAS_W(BW), .OUT_W(OW),
    .SHIFT(8), .NUM_GROUPS(4), .RELU_EN(1)
  ) dut_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_acc(in_acc), .bias(bias_a), .bias_sel(sel_a), .grp_clr(grp_clr),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
  );

  bias_add_relu_stage #(
    .N_adder_tree(N), .ACC_W(AW), .BIAS_W(BW), .OUT_W(OW),
    .SHIFT(8), .NUM_GROUPS(4), .RELU_EN(0)
  ) dut_lin (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_acc(in_acc), .bias(bias_b), .bias_sel(sel_b), .grp_clr(grp_clr),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
  );

  // Bias bank model: group g presents g*256 on every lane.
  always_comb begin
    bias_a = bias_drv;
    bias_b = bias_drv;
    if (use_bank) begin
      for (int i = 0; i < N; i++) begin
        bias_a[BW*i +: BW] = BW'(int'(sel_a) * 256);
        bias_b[BW*i +: BW] = BW'(int'(sel_b) * 256);
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void build(input int b, output logic [N*AW-1:0] acc,
                                output logic [N*BW-1:0] bs,
                                output logic [N*OW-1:0] er, output logic [N*OW-1:0] en);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (b + i) % 16;
      acc[AW*i +: AW] = v_acc[k];
      bs[BW*i +: BW]  = BW'(v_bias[k]);
      er[OW*i +: OW]  = OW'(v_er[k]);
      en[OW*i +: OW]  = OW'(v_en[k]);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [N*AW-1:0] acc, input logic [N*BW-1:0] bs,
                      input logic [N*OW-1:0] er, input logic [N*OW-1:0] en,
                      input int exp_sel);
    int n = 0;
    in_acc   = acc;
    bias_drv = bs;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0, required 1");
    end else begin
      sb.push_back(exp_t'{er: er, en: en});
      if (exp_sel >= 0) chk("bias_sel_at_accept", 256'(sel_a), 256'(exp_sel));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int b);
    logic [N*AW-1:0] acc;
    logic [N*BW-1:0] bs;
    logic [N*OW-1:0] er, en;
    build(b, acc, bs, er, en);
    send(acc, bs, er, en, -1);
  endtask

  task automatic send_bank(input int g);
    logic [N*OW-1:0] e;
    for (int i = 0; i < N; i++) e[OW*i +: OW] = OW'(g);
    send('0, '0, e, e, g);
  endtask

  // Monitor: pops on every handshake and checks stability while stalled.
  initial begin
    logic            stall_prev;
    logic [N*OW-1:0] hold_data;
    exp_t            e;
    stall_prev = 1'b0;
    hold_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (out_valid_a || out_valid_b) chk("valid_relu_vs_lin", 256'(out_valid_b), 256'(out_valid_a));
        if (stall_prev) begin
          chk("hold_valid", 256'(out_valid_a), 256'(1));
          chk("hold_data", 256'(out_data_a), 256'(hold_data));
        end
        if (out_valid_a && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 256'(out_data_a), 256'(0));
            if (out_data_a == '0) begin
              errors++;
              $display("FAIL unexpected_beat: got out_valid 1, required 0");
            end
          end else begin
            e = sb.pop_front();
            chk("data_relu", 256'(out_data_a), 256'(e.er));
            chk("data_lin", 256'(out_data_b), 256'(e.en));
          end
        end
        stall_prev = out_valid_a && !out_ready;
        hold_data  = out_data_a;
      end
    end
  end

  initial begin
    int n;
    v_acc  = '{32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
               32'h0000_0100, 32'hFFFF_FFFF, 32'h007F_FF00, 32'h0080_0000,
               32'hFF80_0000, 32'hFF7F_FF00, 32'h0000_0064, 32'h7FFF_FFFF,
               32'h8000_0000, 32'hFFFF_FC18, 32'h0000_3039, 32'hFFFF_EC78};
    v_bias = '{-13600, 0, 0, -13600, 0, 0, 0, 0,
               0, 0, 131071, 131071, -131072, 1000, -345, 0};
    v_er   = '{202, 32767, 0, 0, 1, 0, 32767, 32767,
               0, 0, 512, 32767, 0, 0, 46, 0};
    v_en   = '{202, 32767, -32768, -54, 1, -1, 32767, 32767,
               -32768, -32768, 512, 32767, -32768, 0, 46, -20};
    in_valid  = 1'b0;
    in_acc    = '0;
    bias_drv  = '0;
    use_bank  = 1'b0;
    grp_clr   = 1'b0;
    out_ready = 1'b1;
    #1 rst_n  = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid_a), 256'(0));
    chk("rst_out_data", 256'(out_data_a), 256'(0));
    chk("rst_bias_sel", 256'(sel_a), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 256'(in_ready_a), 256'(1));
    @(posedge clk);
    #1;

    // Basic path and 2-cycle latency.
    send_vec(0);
    @(negedge clk);
    chk("latency_c1_valid", 256'(out_valid_a), 256'(0));
    @(negedge clk);
    chk("latency_c2_valid", 256'(out_valid_a), 256'(1));
    @(posedge clk);
    #1;

    // Full-rate stream: every vector visits every lane.
    for (int b = 1; b < 16; b++) send_vec(b);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: 5 beats, out_ready low for 4 cycles.
    out_ready = 1'b0;
    fork
      begin
        send_vec(3);
        send_vec(9);
        @(negedge clk);
        chk("bp_in_ready_low", 256'(in_ready_a), 256'(0));
        @(posedge clk);
        #1;
        send_vec(12);
        send_vec(5);
        send_vec(14);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Group sequence and clear coincident with the 6th accept.
    grp_clr = 1'b1;
    @(posedge clk);
    #1 grp_clr = 1'b0;
    use_bank = 1'b1;
    send_bank(0);
    send_bank(1);
    send_bank(2);
    send_bank(3);
    send_bank(0);
    grp_clr = 1'b1;
    send_bank(1);
    grp_clr = 1'b0;
    @(negedge clk);
    chk("bias_sel_after_clr", 256'(sel_a), 256'(0));
    @(posedge clk);
    #1;
    send_bank(0);
    repeat (4) @(posedge clk);
    #1 use_bank = 1'b0;

    // Reset with both stages full.
    out_ready = 1'b0;
    send_vec(2);
    send_vec(7);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 256'(out_valid_a), 256'(0));
    chk("midrst_out_valid_lin", 256'(out_valid_b), 256'(0));
    chk("midrst_out_data", 256'(out_data_a), 256'(0));
    chk("midrst_bias_sel", 256'(sel_a), 256'(0));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 256'(out_valid_a), 256'(0));
    end
    chk("post_rst_in_ready", 256'(in_ready_a), 256'(1));
    @(posedge clk);
    #1;

    send_vec(6);
    send_vec(11);
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
